// File: rtl/dma_read_arbiter.sv
// Two-requester AXI3 read-channel arbiter: one burst in flight, R beats routed to the owner.
// Define DMA_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module dma_read_arbiter #(
  parameter logic [3:0] M0_ID = 4'd2,
  parameter logic [3:0] M1_ID = 4'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s0_araddr,
  input  logic [3:0]  s0_arlen,
  input  logic [2:0]  s0_arsize,
  input  logic [1:0]  s0_arburst,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  output logic        s0_rlast,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  input  logic [31:0] s1_araddr,
  input  logic [3:0]  s1_arlen,
  input  logic [2:0]  s1_arsize,
  input  logic [1:0]  s1_arburst,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        s1_rlast,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [1:0]  m_arlock,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        busy,
  output logic        owner,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      r_state, w_next;
  logic        r_owner, r_err;
  logic [3:0]  r_cnt, r_arid, r_arlen;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [1:0]  r_arburst;

  logic        w_req, w_win, w_grant, w_hs, w_bad;
  logic [3:0]  w_exp_id;

  assign w_req = s0_arvalid | s1_arvalid;
`ifdef DMA_ARB_RR_EN
  // On a tie the requester that did not own the last burst wins.
  assign w_win = (s0_arvalid && s1_arvalid) ? ~r_owner : s1_arvalid;
`else
  assign w_win = ~s0_arvalid;
`endif
  assign w_grant  = (r_state == IDLE) && w_req;
  assign w_hs     = m_rvalid && m_rready;
  assign w_exp_id = r_owner ? M1_ID : M0_ID;
  assign w_bad    = (m_rid != w_exp_id) ||
                    ( m_rlast && (r_cnt != r_arlen)) ||
                    (!m_rlast && (r_cnt == r_arlen));

  always_comb begin
    w_next     = r_state;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    m_rready   = 1'b0;
    m_arvalid  = 1'b0;
    case (r_state)
      IDLE: if (w_req) begin
        w_next     = ADDR;
        s0_arready = ~w_win;
        s1_arready = w_win;
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) w_next = DATA;
      end
      DATA: begin
        m_rready  = r_owner ? s1_rready : s0_rready;
        s0_rvalid = ~r_owner & m_rvalid;
        s1_rvalid = r_owner & m_rvalid;
        if (w_hs && m_rlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= 1'b1;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner   <= w_win;
        r_cnt     <= '0;
        r_arid    <= w_win ? M1_ID      : M0_ID;
        r_araddr  <= w_win ? s1_araddr  : s0_araddr;
        r_arlen   <= w_win ? s1_arlen   : s0_arlen;
        r_arsize  <= w_win ? s1_arsize  : s0_arsize;
        r_arburst <= w_win ? s1_arburst : s0_arburst;
      end
      // Counter wraps freely; a length mismatch only flags err, rlast still ends the burst.
      if ((r_state == DATA) && w_hs) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_bad) r_err <= 1'b1;
      end
    end
  end

  // R payload is broadcast; only the owner sees rvalid.
  assign s0_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rdata  = m_rdata;
  assign s1_rresp  = m_rresp;
  assign s1_rlast  = m_rlast;

  assign m_arid    = r_arid;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = r_arsize;
  assign m_arburst = r_arburst;
  assign m_arlock  = '0;
  assign m_arcache = '0;
  assign m_arprot  = '0;

  assign busy  = (r_state != IDLE);
  assign owner = r_owner;
  assign err   = r_err;
endmodule

// File: doc/dma_read_arbiter.md
# dma_read_arbiter

Two-port AXI3 read-channel arbiter that shares one interconnect read port between two DMA engines, e.g. the LCD DMA and a second peripheral DMA. It sits between the DMA engines' AR/R channels and the crossbar slave port. It grants one requester at a time, allows exactly one burst in flight, and routes R beats back to the owner. It also checks burst length and ID consistency, reporting any mismatch on a sticky error flag.

## Interface
Parameters:
- `M0_ID`, default 2: ARID driven for requester 0 bursts; expected RID.
- `M1_ID`, default 3: ARID driven for requester 1 bursts; expected RID.

Ports (N = 0, 1):
- `clk` — input, 1: sole clock, rising edge.
- `reset` — input, 1: synchronous, active-high.
- `sN_araddr` — input, 32: requester burst address.
- `sN_arlen` — input, 4: beats − 1.
- `sN_arsize` — input, 3: beat size.
- `sN_arburst` — input, 2: burst type.
- `sN_arvalid` — input, 1: request valid.
- `sN_arready` — output, 1: request accepted.
- `sN_rdata` — output, 32: routed read data.
- `sN_rresp` — output, 2: routed response.
- `sN_rlast` — output, 1: routed last.
- `sN_rvalid` — output, 1: routed valid.
- `sN_rready` — input, 1: requester ready.
- `m_arid` — output, 4: burst ID.
- `m_araddr` — output, 32: burst address.
- `m_arlen` — output, 4: burst length.
- `m_arsize` — output, 3: burst size.
- `m_arburst` — output, 2: burst type.
- `m_arlock`, `m_arcache`, `m_arprot` — outputs, 2/4/3: tied 0.
- `m_arvalid` — output, 1: address valid.
- `m_arready` — input, 1: address accepted.
- `m_rid` — input, 4: read ID.
- `m_rdata` — input, 32: read data.
- `m_rresp` — input, 2: read response.
- `m_rlast` — input, 1: last beat.
- `m_rvalid` — input, 1: read valid.
- `m_rready` — output, 1: read ready.
- `busy` — output, 1: state ≠ IDLE.
- `owner` — output, 1: current/last grant index.
- `err` — output, 1: sticky protocol error.

## Operation
- States: IDLE, ADDR, DATA.
- **IDLE:**
  - If any `sN_arvalid`, pick the winner (see Configuration) and assert `sN_arready` for the winner only, combinationally, in that cycle.
  - Capture the winner's address, length, size and burst into the `m_ar*` registers; set `m_arid` to that requester's ID.
  - Set `owner` to the winner, clear the beat counter, and go to ADDR.
- **ADDR:**
  - `m_arvalid` = 1 from registers; the payload is held stable.
  - On `m_arready`, go to DATA.
- **DATA:**
  - `m_rready` = `s[owner]_rready`; `s[owner]_rvalid` = `m_rvalid`.
  - `m_rdata`, `m_rresp` and `m_rlast` are forwarded to the owner.
  - The other requester's `rvalid` = 0.
  - Each R handshake increments the 4-bit beat counter.
  - On a handshake with `m_rlast` = 1, go to IDLE.
- **Error check** (per DATA handshake): `err` is set if any of the following holds:
  - `m_rid` ≠ owner's ID;
  - `m_rlast` = 1 with counter ≠ `m_arlen`;
  - `m_rlast` = 0 with counter = `m_arlen`.
- **After an error:** on a length mismatch, the burst still ends only on `m_rlast`. The counter wraps modulo 16. `err` is cleared only by `reset`.
- **Non-granted requesters:** a requester not granted keeps `arready` = 0; its `arvalid` may stay high indefinitely.

## Timing
- **Reset values:** state IDLE, all `sN_arready`/`sN_rvalid` = 0, `m_arvalid` = 0, `m_rready` = 0, all `m_ar*` = 0, `owner` = 1, `busy` = 0, `err` = 0.
- **Reset mid-burst:** the burst is abandoned and all valids drop the next cycle.
- **Address latency:** `sN_arready` is asserted in the request cycle; `m_arvalid` rises on the next edge. Minimum 1 cycle from request to `m_arvalid`.
- **Back-to-back bursts:** after the `rlast` handshake the state is IDLE on the next edge, so the next grant occurs 1 cycle after `rlast`. Minimum issue gap is 3 cycles (IDLE → ADDR → DATA) plus the beats.
- **R path:** purely combinational; no added latency or buffering.
- **Backpressure:** `m_rready` follows `s[owner]_rready` in the same cycle.
- **Simultaneous requests:** resolved in a single cycle; exactly one `arready` is asserted.

## Configuration
- **`DMA_ARB_RR_EN` defined:** round-robin. The winner is the requester ≠ `owner` if it is requesting, else the other requester. After reset, requester 0 wins the first tie.
- **Undefined:** fixed priority; requester 0 always wins ties. `owner` is still updated for status.

## Test plan
- Single request: s0 requests addr 0x1000, len 15. Expect `m_arid` = 2, `m_araddr` = 0x1000. Return 16 beats with `rlast` on beat 16: all 16 routed to s0, s1 sees no `rvalid`, `err` = 0, and `busy` is low 1 cycle after the last beat.
- Tie with RR: s0 and s1 both held valid. Expect grant order s0, s1, s0, s1 across 4 bursts (IDs 2, 3, 2, 3).
- Tie without `DMA_ARB_RR_EN`: both held valid for 3 bursts. Expect all 3 grants to s0; s1 is granted only after s0 deasserts.
- Backpressure: s1 drops `rready` for 5 cycles mid-burst. Expect `m_rready` low for those 5 cycles and no beats lost or duplicated (16 data words match).
- Errors: return `rlast` on beat 8 of a len-15 burst → `err` = 1 and the state returns to IDLE. Separately, `m_rid` = 5 on any beat → `err` = 1.
- Reset during DATA at beat 4: the next cycle shows `m_rready` = 0, `busy` = 0, `owner` = 1, `err` = 0. A new s1 request after reset is granted normally.
